// File: rtl/dcache_pkg.sv
// Shared types and address helpers for the two-way data cache controller.
// Address layout is {tag, set, 2'b00}; all requests are word aligned.
package dcache_pkg;

    localparam int DC_ADDR_WIDTH = 32;
    localparam int DC_DATA_WIDTH = 32;
    localparam int DC_SET_WIDTH  = 3;
    localparam int DC_TAG_WIDTH  = DC_ADDR_WIDTH - DC_SET_WIDTH - 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_MEM_RD,
        ST_FILL,
        ST_MEM_WR
    } dcache_state_t;

    function automatic logic [DC_TAG_WIDTH-1:0] addr_tag(input logic [DC_ADDR_WIDTH-1:0] addr);
        return addr[DC_ADDR_WIDTH-1:DC_SET_WIDTH+2];
    endfunction

    function automatic logic [DC_SET_WIDTH-1:0] addr_set(input logic [DC_ADDR_WIDTH-1:0] addr);
        return addr[DC_SET_WIDTH+1:2];
    endfunction

    function automatic logic [DC_ADDR_WIDTH-1:0] make_addr(input logic [DC_TAG_WIDTH-1:0] tag,
                                                           input logic [DC_SET_WIDTH-1:0] set);
        return {tag, set, 2'b00};
    endfunction

endpackage

// File: rtl/dcache_controller_lru_table.sv
// Per-set replacement bit: value names the next way to evict.
// Combinational read, single synchronous write, synchronous active-low clear.
module lru_table #(
    parameter int SET_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SET_WIDTH-1:0] rd_set,
    output logic                 rd_val,
    input  logic                 wr_en,
    input  logic [SET_WIDTH-1:0] wr_set,
    input  logic                 wr_val
);

    logic [2**SET_WIDTH-1:0] lru_bits;

    assign rd_val = lru_bits[rd_set];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lru_bits <= '0;
        end else if (wr_en) begin
            lru_bits[wr_set] <= wr_val;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Data cache sequencer: lookup, read-miss refill and write-through stores for a 2-way cache.
// Load hit completes one cycle after accept; misses and stores wait on the memory handshake.
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int ADDR_WIDTH = DC_ADDR_WIDTH,
    parameter int DATA_WIDTH = DC_DATA_WIDTH,
    parameter int SET_WIDTH  = DC_SET_WIDTH,
    parameter int TAG_WIDTH  = DC_TAG_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cpu_req_i,
    input  logic                    cpu_we_i,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr_i,
    input  logic [DATA_WIDTH-1:0]   cpu_wdata_i,
    output logic                    cpu_ready_o,
    output logic [DATA_WIDTH-1:0]   cpu_rdata_o,
    output logic                    busy_o,
    output logic [SET_WIDTH-1:0]    cache_set_o,
    output logic [TAG_WIDTH-1:0]    cache_tag_o,
    input  logic [1:0]              cache_hit_i,
    input  logic [1:0]              cache_valid_i,
    input  logic [2*DATA_WIDTH-1:0] cache_rdata_i,
    output logic                    cache_we_o,
    output logic                    cache_way_o,
    output logic [DATA_WIDTH-1:0]   cache_wdata_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_ack_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

    dcache_state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [DATA_WIDTH-1:0] fill_data;
    logic                  req_we;
    logic                  victim;
    logic [SET_WIDTH-1:0]  req_set;
    logic [TAG_WIDTH-1:0]  req_tag;
    logic                  hit;
    logic                  hit_way;
    logic                  victim_nxt;
    logic                  lru_rd;
    logic                  lru_we;
    logic                  lru_wval;
    logic                  in_mem;

    assign req_set = addr_set(req_addr);
    assign req_tag = addr_tag(req_addr);
    assign hit     = |cache_hit_i;
    // A double hit is illegal upstream; way 0 wins so the choice is deterministic.
    assign hit_way = ~cache_hit_i[0];
    assign victim_nxt = !cache_valid_i[0] ? 1'b0 :
                        !cache_valid_i[1] ? 1'b1 : lru_rd;

    assign in_mem      = (state == ST_MEM_RD) || (state == ST_MEM_WR);
    assign busy_o      = (state != ST_IDLE);
    assign cache_set_o = busy_o ? req_set : '0;
    assign cache_tag_o = busy_o ? req_tag : '0;
    assign mem_addr_o  = in_mem ? make_addr(req_tag, req_set) : '0;
    assign mem_wdata_o = (state == ST_MEM_WR) ? req_wdata : '0;

    lru_table #(
        .SET_WIDTH (SET_WIDTH)
    ) u_lru (
        .clk    (clk),
        .rst_n  (rst_n),
        .rd_set (req_set),
        .rd_val (lru_rd),
        .wr_en  (lru_we),
        .wr_set (req_set),
        .wr_val (lru_wval)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            req_addr  <= '0;
            req_wdata <= '0;
            req_we    <= 1'b0;
            fill_data <= '0;
            victim    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && cpu_req_i) begin
                req_addr  <= cpu_addr_i;
                req_wdata <= cpu_wdata_i;
                req_we    <= cpu_we_i;
            end
            if (state == ST_MEM_RD && mem_ack_i) begin
                fill_data <= mem_rdata_i;
                victim    <= victim_nxt;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        cpu_ready_o   = 1'b0;
        cpu_rdata_o   = '0;
        cache_we_o    = 1'b0;
        cache_way_o   = 1'b0;
        cache_wdata_o = '0;
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        lru_we        = 1'b0;
        lru_wval      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cpu_req_i) state_nxt = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (req_we) begin
                    // Write-through without allocate: only update the array on a hit.
                    if (hit) begin
                        cache_we_o    = 1'b1;
                        cache_way_o   = hit_way;
                        cache_wdata_o = req_wdata;
                        lru_we        = 1'b1;
                        lru_wval      = ~hit_way;
                    end
                    state_nxt = ST_MEM_WR;
                end else if (hit) begin
                    cpu_ready_o = 1'b1;
                    cpu_rdata_o = hit_way ? cache_rdata_i[2*DATA_WIDTH-1:DATA_WIDTH]
                                          : cache_rdata_i[DATA_WIDTH-1:0];
                    lru_we      = 1'b1;
                    lru_wval    = ~hit_way;
                    state_nxt   = ST_IDLE;
                end else begin
                    state_nxt = ST_MEM_RD;
                end
            end
            ST_MEM_RD: begin
                mem_req_o = 1'b1;
                if (mem_ack_i) state_nxt = ST_FILL;
            end
            ST_FILL: begin
                cache_we_o    = 1'b1;
                cache_way_o   = victim;
                cache_wdata_o = fill_data;
                cpu_ready_o   = 1'b1;
                cpu_rdata_o   = fill_data;
                lru_we        = 1'b1;
                lru_wval      = ~victim;
                state_nxt     = ST_IDLE;
            end
            ST_MEM_WR: begin
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
                if (mem_ack_i) begin
                    cpu_ready_o = 1'b1;
                    state_nxt   = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // A request caught by reset is dropped: no completion and no array update.
        if (!rst_n) begin
            cpu_ready_o = 1'b0;
            cache_we_o  = 1'b0;
            lru_we      = 1'b0;
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed scoreboard bench for dcache_controller: stimulus pushes expected events,
// a negedge monitor pops and compares completions, array writes and memory requests.
module tb_dcache_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req_i = 1'b0;
    logic        cpu_we_i = 1'b0;
    logic [31:0] cpu_addr_i = '0;
    logic [31:0] cpu_wdata_i = '0;
    logic        cpu_ready_o;
    logic [31:0] cpu_rdata_o;
    logic        busy_o;
    logic [2:0]  cache_set_o;
    logic [26:0] cache_tag_o;
    logic [1:0]  cache_hit_i = '0;
    logic [1:0]  cache_valid_i = '0;
    logic [63:0] cache_rdata_i = '0;
    logic        cache_we_o;
    logic        cache_way_o;
    logic [31:0] cache_wdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    dcache_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cpu_req_i     (cpu_req_i),
        .cpu_we_i      (cpu_we_i),
        .cpu_addr_i    (cpu_addr_i),
        .cpu_wdata_i   (cpu_wdata_i),
        .cpu_ready_o   (cpu_ready_o),
        .cpu_rdata_o   (cpu_rdata_o),
        .busy_o        (busy_o),
        .cache_set_o   (cache_set_o),
        .cache_tag_o   (cache_tag_o),
        .cache_hit_i   (cache_hit_i),
        .cache_valid_i (cache_valid_i),
        .cache_rdata_i (cache_rdata_i),
        .cache_we_o    (cache_we_o),
        .cache_way_o   (cache_way_o),
        .cache_wdata_o (cache_wdata_o),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_ack_i     (mem_ack_i),
        .mem_rdata_i   (mem_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  hit;
        logic [1:0]  valid;
        logic [31:0] rd0;
        logic [31:0] rd1;
        int          delay;
        logic [31:0] mdata;
        int          rdy_off;
        logic [31:0] exp_rdata;
        int          wr_off;
        logic        wr_way;
        logic [31:0] wr_data;
        logic        mem;
    } vec_t;

    typedef struct { int id; int cyc; logic chk; logic [31:0] data; } rdy_t;
    typedef struct { int id; int cyc; logic way; logic [2:0] set; logic [26:0] tag; logic [31:0] data; } wr_t;
    typedef struct { int id; logic [31:0] addr; logic we; logic [31:0] wdata; } mem_t;

    rdy_t exp_rdy[$];
    wr_t  exp_wr[$];
    mem_t exp_mem[$];
    vec_t vecs[$];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int ack_delay = 0;
    int req_cnt = 0;
    logic [31:0] mem_data = '0;
    logic stray_ack = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: acks in the ack_delay-th request cycle; ack_delay 0 never acks.
    always @(posedge clk) begin
        #1;
        mem_ack_i = 1'b0;
        if (stray_ack) begin
            mem_ack_i = 1'b1;
        end else if (mem_req_o && ack_delay > 0) begin
            req_cnt++;
            if (req_cnt == ack_delay) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = mem_data;
                req_cnt     = 0;
            end
        end else begin
            req_cnt = 0;
        end
    end

    rdy_t mr;
    wr_t  mw;
    mem_t mm;
    always @(negedge clk) begin
        if (cpu_ready_o) begin
            if (exp_rdy.size() == 0) begin
                check("ready_unexpected", {63'd0, cpu_ready_o}, 64'd0);
            end else begin
                mr = exp_rdy.pop_front();
                check($sformatf("v%0d_ready_cycle", mr.id), cyc, mr.cyc);
                if (mr.chk) check($sformatf("v%0d_rdata", mr.id), {32'd0, cpu_rdata_o}, {32'd0, mr.data});
            end
        end
        if (cache_we_o) begin
            if (exp_wr.size() == 0) begin
                check("cache_we_unexpected", {63'd0, cache_we_o}, 64'd0);
            end else begin
                mw = exp_wr.pop_front();
                check($sformatf("v%0d_wr_cycle", mw.id), cyc, mw.cyc);
                check($sformatf("v%0d_wr_way", mw.id), {63'd0, cache_way_o}, {63'd0, mw.way});
                check($sformatf("v%0d_wr_set", mw.id), {61'd0, cache_set_o}, {61'd0, mw.set});
                check($sformatf("v%0d_wr_tag", mw.id), {37'd0, cache_tag_o}, {37'd0, mw.tag});
                check($sformatf("v%0d_wr_data", mw.id), {32'd0, cache_wdata_o}, {32'd0, mw.data});
            end
        end
        if (mem_req_o) begin
            if (exp_mem.size() == 0) begin
                check("mem_req_unexpected", {63'd0, mem_req_o}, 64'd0);
            end else begin
                mm = exp_mem[0];
                check($sformatf("v%0d_mem_addr", mm.id), {32'd0, mem_addr_o}, {32'd0, mm.addr});
                check($sformatf("v%0d_mem_we", mm.id), {63'd0, mem_we_o}, {63'd0, mm.we});
                check($sformatf("v%0d_mem_wdata", mm.id), {32'd0, mem_wdata_o}, {32'd0, mm.wdata});
                if (mem_ack_i) void'(exp_mem.pop_front());
            end
        end
    end

    task automatic wait_idle(input int id);
        bit done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk);
            #1;
            if (!busy_o) done = 1;
        end
        check($sformatf("v%0d_idle_timeout", id), {63'd0, busy_o}, 64'd0);
    endtask

    task automatic run(input int id, input vec_t v);
        int a;
        @(posedge clk);
        #1;
        cache_hit_i   = v.hit;
        cache_valid_i = v.valid;
        cache_rdata_i = {v.rd1, v.rd0};
        ack_delay     = v.delay;
        mem_data      = v.mdata;
        cpu_req_i     = 1'b1;
        cpu_we_i      = v.we;
        cpu_addr_i    = v.addr;
        cpu_wdata_i   = v.wdata;
        a = cyc + 1;
        exp_rdy.push_back('{id, a + v.rdy_off, !v.we, v.exp_rdata});
        if (v.wr_off >= 0)
            exp_wr.push_back('{id, a + v.wr_off, v.wr_way, v.addr[4:2], v.addr[31:5], v.wr_data});
        if (v.mem)
            exp_mem.push_back('{id, v.addr, v.we, v.we ? v.wdata : 32'd0});
        @(posedge clk);
        #1;
        cpu_req_i = 1'b0;
        wait_idle(id);
    endtask

    initial begin
        int a;
        // fields: we addr wdata hit valid rd0 rd1 delay mdata rdy_off exp_rdata wr_off wr_way wr_data mem
        vecs.push_back('{1'b0, 32'h10,   32'h0,    2'b00, 2'b00, 32'h0,    32'h0,    3, 32'hDEADBEEF, 4, 32'hDEADBEEF, 4, 1'b0, 32'hDEADBEEF, 1'b1});
        vecs.push_back('{1'b0, 32'h10,   32'h0,    2'b10, 2'b11, 32'hFFFF, 32'h1234, 0, 32'h0,        0, 32'h1234,     -1, 1'b0, 32'h0,       1'b0});
        vecs.push_back('{1'b0, 32'h10,   32'h0,    2'b00, 2'b11, 32'h0,    32'h0,    1, 32'h55,       2, 32'h55,       2, 1'b0, 32'h55,       1'b1});
        vecs.push_back('{1'b0, 32'h10,   32'h0,    2'b00, 2'b11, 32'h0,    32'h0,    2, 32'h66,       3, 32'h66,       3, 1'b1, 32'h66,       1'b1});
        vecs.push_back('{1'b0, 32'h1008, 32'h0,    2'b00, 2'b00, 32'h0,    32'h0,    1, 32'h1111,     2, 32'h1111,     2, 1'b0, 32'h1111,     1'b1});
        vecs.push_back('{1'b0, 32'h1008, 32'h0,    2'b00, 2'b11, 32'h0,    32'h0,    2, 32'h2222,     3, 32'h2222,     3, 1'b1, 32'h2222,     1'b1});
        vecs.push_back('{1'b0, 32'h18,   32'h0,    2'b00, 2'b01, 32'h0,    32'h0,    1, 32'h3333,     2, 32'h3333,     2, 1'b1, 32'h3333,     1'b1});
        vecs.push_back('{1'b0, 32'h18,   32'h0,    2'b00, 2'b10, 32'h0,    32'h0,    1, 32'h4444,     2, 32'h4444,     2, 1'b0, 32'h4444,     1'b1});
        vecs.push_back('{1'b1, 32'h20,   32'hA5A5, 2'b01, 2'b01, 32'h0,    32'h0,    2, 32'h0,        2, 32'h0,        0, 1'b0, 32'hA5A5,     1'b1});
        vecs.push_back('{1'b1, 32'h20,   32'h5A5A, 2'b00, 2'b00, 32'h0,    32'h0,    1, 32'h0,        1, 32'h0,        -1, 1'b0, 32'h0,       1'b1});
        vecs.push_back('{1'b0, 32'h20,   32'h0,    2'b00, 2'b11, 32'h0,    32'h0,    1, 32'h7777,     2, 32'h7777,     2, 1'b1, 32'h7777,     1'b1});
        vecs.push_back('{1'b0, 32'h04,   32'h0,    2'b11, 2'b11, 32'hAAAA, 32'hBBBB, 0, 32'h0,        0, 32'hAAAA,     -1, 1'b0, 32'h0,       1'b0});
        vecs.push_back('{1'b1, 32'h04,   32'h99,   2'b10, 2'b11, 32'h0,    32'h0,    1, 32'h0,        1, 32'h0,        0, 1'b1, 32'h99,       1'b1});
        vecs.push_back('{1'b0, 32'h04,   32'h0,    2'b00, 2'b11, 32'h0,    32'h0,    1, 32'h88,       2, 32'h88,       2, 1'b0, 32'h88,       1'b1});

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {63'd0, busy_o}, 64'd0);
        check("rst_ready", {63'd0, cpu_ready_o}, 64'd0);
        check("rst_mem_req", {63'd0, mem_req_o}, 64'd0);
        check("rst_cache_we", {63'd0, cache_we_o}, 64'd0);
        check("rst_mem_addr", {32'd0, mem_addr_o}, 64'd0);
        check("rst_set_tag", {34'd0, cache_tag_o, cache_set_o}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (vecs[i]) run(i, vecs[i]);

        // Back-to-back hits with cpu_req_i held: accepts every other cycle.
        @(posedge clk);
        #1;
        cache_hit_i   = 2'b01;
        cache_valid_i = 2'b11;
        cache_rdata_i = {32'h0, 32'hC0DE};
        cpu_req_i     = 1'b1;
        cpu_we_i      = 1'b0;
        cpu_addr_i    = 32'h0C;
        a = cyc + 1;
        for (int k = 0; k < 3; k++) exp_rdy.push_back('{100 + k, a + 2 * k, 1'b1, 32'hC0DE});
        repeat (5) @(posedge clk);
        #1;
        cpu_req_i = 1'b0;
        wait_idle(100);

        // Reset while waiting on a read miss.
        @(posedge clk);
        #1;
        cache_hit_i   = 2'b00;
        cache_valid_i = 2'b00;
        ack_delay     = 0;
        cpu_req_i     = 1'b1;
        cpu_addr_i    = 32'h10;
        exp_mem.push_back('{200, 32'h10, 1'b0, 32'h0});
        @(posedge clk);
        #1;
        cpu_req_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rstrd_in_mem_rd", {63'd0, mem_req_o}, 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_mem.delete();
        check("rstrd_mem_req", {63'd0, mem_req_o}, 64'd0);
        check("rstrd_busy", {63'd0, busy_o}, 64'd0);
        @(negedge clk);
        stray_ack = 1'b1;
        @(posedge clk);
        #2;
        stray_ack = 1'b0;
        @(negedge clk);
        check("stray_ack_busy", {63'd0, busy_o}, 64'd0);
        check("stray_ack_ready", {63'd0, cpu_ready_o}, 64'd0);

        // LRU for set 3 was 1 before reset; a cleared table evicts way 0.
        run(300, '{1'b0, 32'h0C, 32'h0, 2'b00, 2'b11, 32'h0, 32'h0, 1, 32'hBEEF, 2, 32'hBEEF, 2, 1'b0, 32'hBEEF, 1'b1});

        repeat (3) @(posedge clk);
        check("drain_ready", exp_rdy.size(), 64'd0);
        check("drain_wr", exp_wr.size(), 64'd0);
        check("drain_mem", exp_mem.size(), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
